// File: rtl/scroll_sequencer.sv
// -----------------------------------------------------------------------------
// scroll_sequencer
//
// Scrolls a message held in a 16-entry, 7-bit glyph buffer across six
// 7-segment digits (hex5 = leftmost). The message advances automatically on
// prescaler wrap, or manually on a rising edge of step while paused.
//
// Parameters
//   DIV_SLOW  prescaler terminal count in normal mode
//   DIV_FAST  prescaler terminal count when fastmode = 1
//
// Ports
//   CLOCK_50        sole clock, rising edge
//   RESET           asynchronous, active-high reset
//   dir             1 = scroll left (head increments), 0 = scroll right
//   fastmode        selects DIV_FAST instead of DIV_SLOW
//   pause           freezes the prescaler and enables manual stepping
//   step            manual advance request (rising edge acts, pause = 1 only)
//   wr_en/wr_addr/wr_data  glyph buffer write port (active-low glyphs)
//   len_we/len_in   message length load (clamped to 1..16), clears head
//   hex5..hex0      registered display glyphs
//   head            message index currently shown on hex5
//   tick            one-cycle pulse whenever head advances
// -----------------------------------------------------------------------------
module scroll_sequencer #(
    parameter int DIV_SLOW = 20000000,
    parameter int DIV_FAST = 9000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       dir,
    input  logic       fastmode,
    input  logic       pause,
    input  logic       step,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [6:0] wr_data,
    input  logic       len_we,
    input  logic [4:0] len_in,
    output logic [6:0] hex5,
    output logic [6:0] hex4,
    output logic [6:0] hex3,
    output logic [6:0] hex2,
    output logic [6:0] hex1,
    output logic [6:0] hex0,
    output logic [3:0] head,
    output logic       tick
);

    localparam logic [24:0] L_DIV_SLOW = 25'(DIV_SLOW);
    localparam logic [24:0] L_DIV_FAST = 25'(DIV_FAST);
    localparam logic [6:0]  L_BLANK    = 7'b1111111;

    // State
    logic [24:0] r_presc;
    logic        r_step_q;
    logic [4:0]  r_len;
    logic [3:0]  r_head;
    logic        r_tick;
    logic [6:0]  r_buf  [16];
    logic [6:0]  r_disp [6];    // r_disp[j] drives hex(5-j)

    // Combinational
    logic [24:0] w_div;
    logic        w_auto;
    logic        w_manual;
    logic        w_advance;
    logic [4:0]  w_head_p1;
    logic [3:0]  w_head_fwd;
    logic [3:0]  w_head_back;
    logic [4:0]  w_len_load;
    logic [3:0]  w_idx    [6];
    logic [4:0]  w_idx_p1 [5];

    assign w_div = fastmode ? L_DIV_FAST : L_DIV_SLOW;

    // ">=" rather than "==" so that switching to a shorter period while the
    // count is already past it wraps on the very next edge.
    assign w_auto    = !pause && (r_presc >= w_div);
    assign w_manual  = pause && step && !r_step_q;
    assign w_advance = w_auto || w_manual;

    // head stays < len, so a single compare replaces the modulo.
    assign w_head_p1   = {1'b0, r_head} + 5'd1;
    assign w_head_fwd  = (w_head_p1 == r_len) ? 4'd0 : w_head_p1[3:0];
    assign w_head_back = (r_head == 4'd0) ? 4'(r_len - 5'd1) : (r_head - 4'd1);

    assign w_len_load = (len_in == 5'd0)  ? 5'd1  :
                        (len_in > 5'd16)  ? 5'd16 : len_in;

    // Display index chain: each digit is the previous one plus one, wrapped at
    // len. Short messages wrap several times, repeating across the display.
    assign w_idx[0] = r_head;
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_idx
            assign w_idx_p1[gi]  = {1'b0, w_idx[gi]} + 5'd1;
            assign w_idx[gi + 1] = (w_idx_p1[gi] == r_len) ? 4'd0 : w_idx_p1[gi][3:0];
        end
    endgenerate

    // Sequencing: prescaler, step edge detect, length and head
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_presc  <= '0;
            r_step_q <= 1'b0;
            r_len    <= 5'd6;
            r_head   <= 4'd0;
            r_tick   <= 1'b0;
        end else begin
            r_step_q <= step;
            if (len_we) begin
                // Length load overrides any coincident advance.
                r_len   <= w_len_load;
                r_head  <= 4'd0;
                r_presc <= '0;
                r_tick  <= 1'b0;
            end else begin
                if (!pause) begin
                    r_presc <= w_auto ? 25'd0 : (r_presc + 25'd1);
                end
                r_tick <= w_advance;
                if (w_advance) begin
                    r_head <= dir ? w_head_fwd : w_head_back;
                end
            end
        end
    end

    // Glyph buffer; reset to blank, so it lives in registers.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 16; i++) begin
                r_buf[i] <= L_BLANK;
            end
        end else if (wr_en) begin
            r_buf[wr_addr] <= wr_data;
        end
    end

    // Display registers follow head/buffer with one cycle of latency.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            for (int j = 0; j < 6; j++) begin
                r_disp[j] <= L_BLANK;
            end
        end else begin
            for (int j = 0; j < 6; j++) begin
                r_disp[j] <= r_buf[w_idx[j]];
            end
        end
    end

    assign hex5 = r_disp[0];
    assign hex4 = r_disp[1];
    assign hex3 = r_disp[2];
    assign hex2 = r_disp[3];
    assign hex1 = r_disp[4];
    assign hex0 = r_disp[5];
    assign head = r_head;
    assign tick = r_tick;

endmodule

// File: tb/tb_scroll_sequencer.sv
// -----------------------------------------------------------------------------
// tb_scroll_sequencer
//
// Directed stimulus against scroll_sequencer (DIV_SLOW = 7, DIV_FAST = 3).
// A behavioural model (message index arithmetic with %, phase counter) is
// compared with the DUT on every falling edge; literal expectations pin the
// model at the key points.
// -----------------------------------------------------------------------------
module tb_scroll_sequencer;

    localparam int DS = 7;
    localparam int DF = 3;

    localparam logic [6:0] G_S  = 7'b0010010;
    localparam logic [6:0] G_C  = 7'b0100111;
    localparam logic [6:0] G_R  = 7'b0101111;
    localparam logic [6:0] G_O  = 7'b0100011;
    localparam logic [6:0] G_L  = 7'b1000111;
    localparam logic [6:0] G_BL = 7'b1111111;

    logic       CLOCK_50;
    logic       RESET;
    logic       dir, fastmode, pause, step, wr_en, len_we;
    logic [3:0] wr_addr;
    logic [6:0] wr_data;
    logic [4:0] len_in;
    logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;
    logic [3:0] head;
    logic       tick;

    int n_cmp = 0;
    int n_mis = 0;
    bit chk_en = 0;

    scroll_sequencer #(.DIV_SLOW(DS), .DIV_FAST(DF)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .dir      (dir),
        .fastmode (fastmode),
        .pause    (pause),
        .step     (step),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .len_we   (len_we),
        .len_in   (len_in),
        .hex5     (hex5),
        .hex4     (hex4),
        .hex3     (hex3),
        .hex2     (hex2),
        .hex1     (hex1),
        .hex0     (hex0),
        .head     (head),
        .tick     (tick)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    // ---------------- behavioural model ----------------
    logic [6:0] m_buf [16];
    logic [6:0] m_hex [6];      // m_hex[K] is the expected hexK
    int         m_len, m_head, m_phase;
    bit         m_stepq, m_tick;

    function automatic int clamp_len(input int v);
        return (v == 0) ? 1 : ((v > 16) ? 16 : v);
    endfunction

    function automatic bit model_adv();
        return (!pause && (m_phase >= (fastmode ? DF : DS))) ||
               (pause && step && !m_stepq);
    endfunction

    always @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 16; i++) m_buf[i] <= G_BL;
            for (int k = 0; k < 6; k++)  m_hex[k] <= G_BL;
            m_len   <= 6;
            m_head  <= 0;
            m_phase <= 0;
            m_stepq <= 0;
            m_tick  <= 0;
        end else begin
            for (int k = 0; k < 6; k++) m_hex[k] <= m_buf[(m_head + 5 - k) % m_len];
            if (wr_en) m_buf[wr_addr] <= wr_data;
            m_stepq <= step;
            if (len_we) begin
                m_len   <= clamp_len(int'(len_in));
                m_head  <= 0;
                m_phase <= 0;
                m_tick  <= 0;
            end else if (model_adv()) begin
                m_head  <= dir ? (m_head + 1) % m_len : (m_head + m_len - 1) % m_len;
                m_tick  <= 1;
                m_phase <= pause ? m_phase : 0;
            end else begin
                m_tick  <= 0;
                m_phase <= pause ? m_phase : m_phase + 1;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (chk_en) begin
            check("model head", 64'(head), 64'(m_head));
            check("model tick", 64'(tick), 64'(m_tick));
            check("model hex", {hex5, hex4, hex3, hex2, hex1, hex0},
                  {m_hex[5], m_hex[4], m_hex[3], m_hex[2], m_hex[1], m_hex[0]});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic wait_tick(output int cnt);
        cnt = 0;
        do begin
            @(negedge CLOCK_50);
            cnt++;
        end while (tick !== 1'b1 && cnt < 40);
        if (tick !== 1'b1) check("tick timeout", 64'(tick), 64'd1);
    endtask

    task automatic load_len(input logic [4:0] l);
        len_we = 1'b1;
        len_in = l;
        cyc(1);
        len_we = 1'b0;
    endtask

    task automatic write_glyph(input logic [3:0] a, input logic [6:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        cyc(1);
        wr_en   = 1'b0;
    endtask

    logic [6:0] msg [6];
    int cnt, ticks;

    initial begin
        msg = '{G_S, G_C, G_R, G_O, G_L, G_L};
        RESET = 1'b0; dir = 1'b1; fastmode = 1'b0; pause = 1'b1; step = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; len_we = 1'b0; len_in = '0;
        #2 RESET = 1'b1;
        #1 chk_en = 1;
        cyc(3);
        check("reset head", 64'(head), 64'd0);
        check("reset tick", 64'(tick), 64'd0);
        check("reset hex", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{G_BL}});
        RESET = 1'b0;

        // Load "ScroLL", scroll left
        for (int i = 0; i < 6; i++) write_glyph(4'(i), msg[i]);
        pause = 1'b0; dir = 1'b1;
        load_len(5'd6);
        wait_tick(cnt);
        check("left first tick latency", 64'(cnt), 64'd8);
        check("left first head", 64'(head), 64'd1);
        cyc(1);
        check("left hex after tick", {hex5, hex4, hex3, hex2, hex1, hex0},
              {G_C, G_R, G_O, G_L, G_L, G_S});
        wait_tick(cnt);
        check("left second interval", 64'(cnt), 64'd7);
        check("left second head", 64'(head), 64'd2);
        for (int i = 3; i <= 6; i++) begin
            wait_tick(cnt);
            check("left interval", 64'(cnt), 64'd8);
            check("left head seq", 64'(head), 64'(i % 6));
        end

        // Scroll right
        dir = 1'b0;
        load_len(5'd6);
        wait_tick(cnt);
        check("right first tick latency", 64'(cnt), 64'd8);
        check("right first head", 64'(head), 64'd5);
        cyc(1);
        check("right hex after tick", {hex5, hex4, hex3, hex2, hex1, hex0},
              {G_L, G_S, G_C, G_R, G_O, G_L});

        // Step edges ignored while running
        load_len(5'd6);
        ticks = 0;
        for (int i = 0; i < 7; i++) begin
            step = (i < 2 || i == 4);
            cyc(1);
            if (tick === 1'b1) ticks++;
        end
        step = 1'b0;
        check("step ignored unpaused", 64'(ticks), 64'd0);

        // Paused manual stepping
        pause = 1'b1; dir = 1'b1;
        load_len(5'd6);
        ticks = 0;
        for (int s = 0; s < 3; s++) begin
            step = 1'b1;
            for (int i = 0; i < 4; i++) begin cyc(1); if (tick === 1'b1) ticks++; end
            step = 1'b0;
            for (int i = 0; i < 4; i++) begin cyc(1); if (tick === 1'b1) ticks++; end
        end
        for (int i = 0; i < 20; i++) begin cyc(1); if (tick === 1'b1) ticks++; end
        check("manual tick count", 64'(ticks), 64'd3);
        check("manual head", 64'(head), 64'd3);

        // Write to a displayed index (head=3 -> hex2 shows buf[0])
        write_glyph(4'd0, 7'h55);
        check("write not yet visible", 64'(hex2), 64'(G_S));
        cyc(1);
        check("write visible", 64'(hex2), 64'h55);
        write_glyph(4'd0, G_S);

        // len_in = 0 -> len 1
        load_len(5'd0);
        cyc(1);
        check("len1 hex", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{G_S}});
        step = 1'b1;
        cyc(1);
        check("len1 step tick", 64'(tick), 64'd1);
        check("len1 step head", 64'(head), 64'd0);
        step = 1'b0;
        cyc(1);

        // len_in = 20 -> len 16, fast mode
        for (int i = 6; i < 16; i++) write_glyph(4'(i), 7'(i * 9));
        fastmode = 1'b1; pause = 1'b0;
        load_len(5'd20);
        for (int i = 0; i < 16; i++) begin
            wait_tick(cnt);
            check("len16 fast interval", 64'(cnt), 64'd4);
        end
        check("len16 wrap head", 64'(head), 64'd0);

        // len_we coincident with an advance
        fastmode = 1'b0;
        load_len(5'd6);
        cyc(7);
        len_we = 1'b1; len_in = 5'd6;
        cyc(1);
        len_we = 1'b0;
        check("coincide head", 64'(head), 64'd0);
        check("coincide tick", 64'(tick), 64'd0);
        wait_tick(cnt);
        check("coincide next interval", 64'(cnt), 64'd8);

        // fastmode switch with prescaler at 5
        load_len(5'd6);
        cyc(5);
        fastmode = 1'b1;
        cyc(1);
        check("fast switch wrap tick", 64'(tick), 64'd1);
        for (int i = 0; i < 2; i++) begin
            wait_tick(cnt);
            check("fast interval", 64'(cnt), 64'd4);
        end

        // Reset mid-scroll
        cyc(3);
        #2 RESET = 1'b1;
        #1;
        check("midreset hex", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{G_BL}});
        check("midreset head", 64'(head), 64'd0);
        check("midreset tick", 64'(tick), 64'd0);
        @(negedge CLOCK_50);
        RESET = 1'b0; fastmode = 1'b0;
        wait_tick(cnt);
        check("post-reset latency", 64'(cnt), 64'(DS + 1));
        check("post-reset head", 64'(head), 64'd1);
        cyc(1);
        check("post-reset blank", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{G_BL}});
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
